// File: rtl/dist_calc_nd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dist_calc_nd
// Description : DIM-dimensional squared-L2 / L1 distance with threshold hit,
//               one dimension per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module dist_calc_nd #(
   parameter  int W     = 32,
   parameter  int DIM   = 3,
   localparam int ACC_W = 2*W + $clog2(DIM)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIM*W-1:0] a_flat,
   input  logic [DIM*W-1:0] b_flat,
   input  logic [ACC_W-1:0] thresh,
   input  logic             mode,
   output logic [ACC_W-1:0] res,
   output logic             hit,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [IDX_W-1:0] c_last = IDX_W'(DIM - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_res;
   logic             r_hit;
   logic [ACC_W-1:0] r_acc;
   logic [IDX_W-1:0] r_idx;
   logic [ACC_W-1:0] r_thresh;
   logic             r_mode;
   logic [W-1:0]     r_a [DIM];
   logic [W-1:0]     r_b [DIM];

   logic [W-1:0]     w_a;
   logic [W-1:0]     w_b;
   logic [W:0]       w_diff;
   logic [W:0]       w_abs;
   logic [2*W-1:0]   w_mag;
   logic [2*W-1:0]   w_term;
   logic [ACC_W-1:0] w_sum;

   // Sign-extend both coordinates by one bit so the difference never wraps.
   assign w_a    = r_a[r_idx];
   assign w_b    = r_b[r_idx];
   assign w_diff = {w_a[W-1], w_a} - {w_b[W-1], w_b};
   assign w_abs  = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
   assign w_mag  = (2*W)'(w_abs);
   assign w_term = r_mode ? w_mag : (w_mag * w_mag);
   assign w_sum  = r_acc + ACC_W'(w_term);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_hit       <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_thresh    <= '0;
         r_mode      <= 1'b0;
         for (int k = 0; k < DIM; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  for (int k = 0; k < DIM; k++) begin
                     r_a[k] <= a_flat[k*W +: W];
                     r_b[k] <= b_flat[k*W +: W];
                  end
                  r_thresh   <= thresh;
                  r_mode     <= mode;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               r_acc <= w_sum;
               if (r_idx == c_last) begin
                  r_idx       <= '0;
                  r_res       <= w_sum;
                  r_hit       <= (w_sum <= r_thresh);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign hit       = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_dist_calc_nd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dist_calc_nd
// Description : Self-checking bench for dist_calc_nd (DIM=3 and DIM=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dist_calc_nd;
   localparam int W     = 32;
   localparam int DIM   = 3;
   localparam int ACC_W = 66;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             in_valid, in_ready, mode, hit, out_valid, out_ready;
   logic [DIM*W-1:0] a_flat, b_flat;
   logic [ACC_W-1:0] thresh, res;

   logic             in_valid1, in_ready1, mode1, hit1, out_valid1, out_ready1;
   logic [W-1:0]     a1, b1;
   logic [2*W-1:0]   thresh1, res1;

   always #5 CLK = ~CLK;

   dist_calc_nd #(.W(W), .DIM(DIM)) u_dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .a_flat(a_flat), .b_flat(b_flat), .thresh(thresh), .mode(mode),
      .res(res), .hit(hit), .out_valid(out_valid), .out_ready(out_ready));

   dist_calc_nd #(.W(W), .DIM(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid1), .in_ready(in_ready1),
      .a_flat(a1), .b_flat(b1), .thresh(thresh1), .mode(mode1),
      .res(res1), .hit(hit1), .out_valid(out_valid1), .out_ready(out_ready1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DIM*W-1:0] pack3(input logic [W-1:0] x0, x1, x2);
      return {x2, x1, x0};
   endfunction

   // Distance straight from the definition, using wide integer arithmetic.
   function automatic logic [ACC_W-1:0] model(input logic [DIM*W-1:0] a, b, input logic m);
      logic [ACC_W-1:0] s = '0;
      for (int k = 0; k < DIM; k++) begin
         longint      d  = longint'($signed(a[k*W +: W])) - longint'($signed(b[k*W +: W]));
         logic [63:0] ad = (d < 0) ? 64'(-d) : 64'(d);
         s += m ? ACC_W'(ad) : ACC_W'(ad * ad);
      end
      return s;
   endfunction

   function automatic logic [W-1:0] rand_coord();
      case ($urandom_range(0, 3))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after DONE exits.
   task automatic op(input logic [DIM*W-1:0] a, b, input logic [ACC_W-1:0] th, input logic m,
                     output logic [ACC_W-1:0] r, output logic h, output int lat);
      a_flat = a; b_flat = b; thresh = th; mode = m; in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge CLK); lat++; @(negedge CLK);
      end
      r = res; h = hit;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   typedef struct {
      logic [DIM*W-1:0] a;
      logic [DIM*W-1:0] b;
      logic [ACC_W-1:0] th;
      logic             m;
      logic [ACC_W-1:0] er;
      logic             eh;
   } vec_t;

   vec_t             tbl [8];
   logic [ACC_W-1:0] r_got, exp_v, th_v;
   logic             h_got;
   int               lat;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DIM*W-1:0] ra, rb;
      logic             rm;
      logic [ACC_W-1:0] exp_q [$];
      logic [2*W-1:0]   exp1_q [$];
      int               n_sent, n_got, last_out, spur;

      in_valid = 0; out_ready = 1; a_flat = '0; b_flat = '0; thresh = '0; mode = 0;
      in_valid1 = 0; out_ready1 = 1; a1 = '0; b1 = '0; thresh1 = '0; mode1 = 0;

      tbl[0] = '{pack3(3, 4, 0), '0, 66'd25, 1'b0, 66'd25, 1'b1};
      tbl[1] = '{pack3(3, 4, 0), '0, 66'd24, 1'b0, 66'd25, 1'b0};
      tbl[2] = '{pack3(3, 4, 0), '0, 66'd6,  1'b1, 66'd7,  1'b0};
      tbl[3] = '{pack3(-5, 2, -1), pack3(5, -2, 1), 66'd200, 1'b0, 66'd120, 1'b1};
      tbl[4] = '{pack3(-5, 2, -1), pack3(5, -2, 1), 66'd16,  1'b1, 66'd16,  1'b1};
      tbl[5] = '{pack3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                 pack3(32'h80000000, 32'h80000000, 32'h80000000),
                 66'd0, 1'b0, 66'h2_FFFF_FFFA_0000_0003, 1'b0};
      tbl[6] = '{pack3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                 pack3(32'h80000000, 32'h80000000, 32'h80000000),
                 {ACC_W{1'b1}}, 1'b1, 66'h2_FFFF_FFFD, 1'b1};
      tbl[7] = '{pack3(32'h80000000, 32'h80000000, 32'h80000000),
                 pack3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                 66'h2_FFFF_FFFA_0000_0003, 1'b0, 66'h2_FFFF_FFFA_0000_0003, 1'b1};

      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_res", res, 0);
      chk("reset_hit", hit, 0);
      @(negedge CLK); RST = 0;
      @(negedge CLK);
      chk("reset_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         op(tbl[i].a, tbl[i].b, tbl[i].th, tbl[i].m, r_got, h_got, lat);
         chk($sformatf("tbl%0d_res", i), r_got, tbl[i].er);
         chk($sformatf("tbl%0d_hit", i), h_got, tbl[i].eh);
         chk($sformatf("tbl%0d_latency", i), lat, DIM);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      end

      for (int i = 0; i < 24; i++) begin
         ra = pack3(rand_coord(), rand_coord(), rand_coord());
         rb = pack3(rand_coord(), rand_coord(), rand_coord());
         rm = 1'($urandom_range(0, 1));
         exp_v = model(ra, rb, rm);
         case ($urandom_range(0, 2))
            0:       th_v = exp_v - 1;
            1:       th_v = exp_v;
            default: th_v = exp_v + 1;
         endcase
         op(ra, rb, th_v, rm, r_got, h_got, lat);
         chk($sformatf("rnd%0d_res", i), r_got, exp_v);
         chk($sformatf("rnd%0d_hit", i), h_got, (exp_v <= th_v));
      end

      // Backpressure: result held while a new set is offered and refused.
      out_ready = 0;
      a_flat = pack3(1, 2, 3); b_flat = '0; thresh = 66'd14; mode = 0; in_valid = 1;
      @(posedge CLK); @(negedge CLK);
      in_valid = 0; lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge CLK); lat++; @(negedge CLK);
      end
      chk("bp_latency", lat, DIM);
      a_flat = pack3(10, 0, 0); thresh = 66'd0; in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); @(negedge CLK);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_res", res, 66'd14);
         chk("bp_hit", hit, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge CLK); @(negedge CLK);
      chk("bp_valid_drop", out_valid, 0);
      chk("bp_ready_back", in_ready, 1);
      @(posedge CLK); @(negedge CLK);
      in_valid = 0;
      chk("bp_next_accepted", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge CLK); lat++; @(negedge CLK);
      end
      chk("bp_next_latency", lat, DIM);
      chk("bp_next_res", res, 66'd100);
      chk("bp_next_hit", hit, 0);
      @(posedge CLK); @(negedge CLK);

      // Asynchronous reset while idx=1 in ACCUM.
      op(pack3(3, 4, 0), '0, 66'd25, 1'b0, r_got, h_got, lat);
      a_flat = pack3(7, 7, 7); b_flat = '0; thresh = '1; mode = 0; in_valid = 1;
      @(posedge CLK); @(negedge CLK);
      in_valid = 0;
      @(posedge CLK);
      #2 RST = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_hit", hit, 0);
      @(negedge CLK); RST = 0;
      spur = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (out_valid) spur++;
      end
      chk("rst_no_result", spur, 0);
      chk("rst_in_ready", in_ready, 1);
      op(pack3(1, 2, 3), '0, 66'd13, 1'b0, r_got, h_got, lat);
      chk("rst_fresh_res", r_got, 66'd14);
      chk("rst_fresh_hit", h_got, 0);
      chk("rst_fresh_latency", lat, DIM);

      // Back-to-back, DIM=3: in_valid and out_ready held high.
      n_sent = 0; n_got = 0; last_out = -1;
      for (int cyc = 0; cyc < 80 && n_got < 4; cyc++) begin
         if (out_valid) begin
            if (exp_q.size() > 0) chk("b2b_res", res, exp_q.pop_front());
            else chk("b2b_spurious", 1, 0);
            if (last_out >= 0) chk("b2b_interval", cyc - last_out, DIM + 2);
            last_out = cyc; n_got++;
         end
         if (in_ready) begin
            if (n_sent < 4) begin
               a_flat = pack3(rand_coord(), rand_coord(), rand_coord());
               b_flat = pack3(rand_coord(), rand_coord(), rand_coord());
               mode = 1'($urandom_range(0, 1));
               in_valid = 1;
               exp_q.push_back(model(a_flat, b_flat, mode));
               n_sent++;
            end else begin
               in_valid = 0;
            end
         end
         @(posedge CLK); @(negedge CLK);
      end
      in_valid = 0;
      chk("b2b_count", n_got, 4);

      // Back-to-back, DIM=1 build.
      n_sent = 0; n_got = 0; last_out = -1;
      for (int cyc = 0; cyc < 60 && n_got < 4; cyc++) begin
         if (out_valid1) begin
            if (exp1_q.size() > 0) chk("d1_res", res1, exp1_q.pop_front());
            else chk("d1_spurious", 1, 0);
            chk("d1_hit", hit1, (res1 <= thresh1));
            if (last_out >= 0) chk("d1_interval", cyc - last_out, 3);
            last_out = cyc; n_got++;
         end
         if (in_ready1) begin
            if (n_sent < 4) begin
               a1 = rand_coord(); b1 = rand_coord();
               mode1 = 1'($urandom_range(0, 1));
               exp_v = model({64'b0, a1}, {64'b0, b1}, mode1);
               thresh1 = exp_v[2*W-1:0] + 64'($urandom_range(0, 1)) - 64'd1;
               in_valid1 = 1;
               exp1_q.push_back(exp_v[2*W-1:0]);
               n_sent++;
            end else begin
               in_valid1 = 0;
            end
         end
         @(posedge CLK); @(negedge CLK);
      end
      in_valid1 = 0;
      chk("d1_count", n_got, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
